// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the control unit and the multiply/divide unit.
// Latency: none (wires only).
// Backpressure: none; the control unit watches busy/done and stalls itself.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  // Control-unit side: issues requests, reads results.
  modport master (
    output start, op, A, B,
    input  Hi, Lo, busy, done, div_by_zero
  );

  // Arithmetic-unit side.
  modport slave (
    input  start, op, A, B,
    output Hi, Lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed mult/div (shift-add / restoring), results held in Hi/Lo.
// Latency: 33 cycles start-to-done; divide by zero answers in 1 cycle.
// Backpressure: none; start is ignored while busy, with no queueing.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  mult_div_unit_if.slave    bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  state_t               state_q, state_d;
  logic                 op_q, op_d;
  logic                 sgn_q, sgn_d;    // product / quotient sign
  logic                 rsgn_q, rsgn_d;  // remainder sign (follows dividend)
  logic [WIDTH-1:0]     opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;    // product, or remainder:quotient
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d, dbz_q, dbz_d;
  logic                 busy;

  logic                 dbz_req;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH:0]     shifted;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   prod_fix;

  assign dbz_req = bus.start && bus.op && (bus.B == '0);

  // State register and datapath registers; reset aborts any operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      sgn_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      rsgn_q  <= rsgn_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: divide by zero is answered without leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start && !dbz_req) state_d = S_CALC;
      S_CALC:   if (cnt_q == LAST)         state_d = S_FINISH;
      S_FINISH:                            state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath: operand capture, one shift-add or restoring step per cycle, sign fix-up.
  always_comb begin
    op_d    = op_q;
    sgn_d   = sgn_q;
    rsgn_d  = rsgn_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;

    // The most negative value negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    a_mag   = bus.A[WIDTH-1] ? -bus.A : bus.A;
    b_mag   = bus.B[WIDTH-1] ? -bus.B : bus.B;
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    shifted = {acc_q, 1'b0};
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    prod_fix = sgn_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (dbz_req) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            op_d   = bus.op;
            sgn_d  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            rsgn_d = bus.A[WIDTH-1];
            cnt_d  = '0;
            opnd_d = bus.op ? b_mag : a_mag;
            acc_d  = {{WIDTH{1'b0}}, (bus.op ? a_mag : b_mag)};
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!op_q) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
          acc_d = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        end else begin
          acc_d = shifted[2*WIDTH-1:0];
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
        if (!op_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          lo_d = sgn_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
          hi_d = rsgn_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: ;
    endcase
  end

  assign bus.Hi          = hi_q;
  assign bus.Lo          = lo_q;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit for the MIPS datapath, implementing `mult` and `div`. It takes its operands from the A and B register outputs and writes results into internal Hi and Lo registers, which the register-bank write-back mux reads for `mfhi` and `mflo`. The control unit starts an operation with a one-cycle pulse and stalls in a wait state until `done` is asserted.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Hi and Lo are each `WIDTH` bits wide.

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous reset, active-low. Clears all state while low.
- `start`, in, 1: request pulse. Sampled only in IDLE.
- `op`, in, 1: operation select, sampled with `start`. 0 = mult, 1 = div.
- `A`, in, `WIDTH`: multiplicand or dividend, sampled with `start`.
- `B`, in, `WIDTH`: multiplier or divisor, sampled with `start`.
- `Hi`, out, `WIDTH`: upper product word, or remainder.
- `Lo`, out, `WIDTH`: lower product word, or quotient.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `div_by_zero`, out, 1: one-cycle pulse, concurrent with `done`, on a div whose B = 0.

## Operation
States:
- IDLE: waits for `start`.
- CALC: 32 iterations, counted by a 5-bit iteration counter.
- FINISH: sign fix-up and result write.

IDLE with `start` = 1:
- Latch `op`.
- Latch |A| and |B| as unsigned magnitudes.
- Latch a result-sign flag:
  - mult: A[31] ^ B[31].
  - div: quotient sign A[31] ^ B[31]; remainder sign A[31].
- Clear the counter and go to CALC.
- Exception: if `op` = 1 and B = 0, stay in IDLE, pulse `done` and `div_by_zero`, and leave Hi/Lo unchanged.

CALC, mult:
- Unsigned shift-add over a 64-bit accumulator.
- Each iteration: if the accumulator LSB is 1, add the multiplicand to the upper half with carry-out kept; then shift the whole accumulator right by 1.

CALC, div:
- Restoring division over a 64-bit remainder:quotient register.
- Each iteration: shift left by 1; trial-subtract the divisor from the upper 33 bits; if non-negative, keep the difference and set quotient bit 0 to 1.

CALC exit: after the counter reaches 31, go to FINISH.

FINISH:
- mult: {Hi, Lo} = the 64-bit product, two's-complement negated if the sign flag is set.
- div: Lo = quotient, negated if the quotient sign is set. Hi = remainder, negated if the remainder sign is set. Division truncates toward zero.
- Pulse `done`, then go to IDLE.

Arithmetic and width rules:
- |0x80000000| is treated as 2^31 unsigned, so there is no overflow trap.
- 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0.

Hi/Lo hold their value until the next FINISH or reset. Operand inputs are ignored outside the start cycle.

## Timing
- Reset values: state IDLE, Hi = 0, Lo = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, counter = 0.
- Latency, with `start` sampled at edge k:
  - `busy` = 1 from edge k until edge k+33.
  - CALC occupies edges k+1 through k+32.
  - FINISH at edge k+33 updates Hi/Lo and raises `done` for exactly one cycle, from edge k+33 to edge k+34.
  - Total: 33 cycles from start to a visible result.
- Divide by zero: `done` and `div_by_zero` are high for one cycle, from edge k to edge k+1. `busy` never rises.
- `start` while `busy` is ignored, with no queueing.
- `start` in the same cycle as `done` (state IDLE after FINISH) is accepted normally.
- Reset asserted mid-operation aborts immediately. Outputs return to their reset values and no `done` is produced.
- `done` and `div_by_zero` are registered outputs. Hi/Lo are valid in the same cycle that `done` is high.

## Test plan
- mult, A = 7, B = 0xFFFFFFFD (−3) → Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB. `done` high 33 cycles after the start edge; `busy` high for 33 cycles.
- mult, A = B = 0x80000000 → Hi = 0x40000000, Lo = 0x00000000.
- div, A = 0xFFFFFFF9 (−7), B = 2 → Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF.
- div, A = 0x80000000, B = 0xFFFFFFFF → Lo = 0x80000000, Hi = 0.
- div by zero, starting from Hi/Lo = 0x12345678/0x9ABCDEF0 → next cycle `done` = `div_by_zero` = 1, `busy` = 0, Hi/Lo unchanged.
- Robustness sequence: a second `start` at cycle 10 of a running mult is ignored and the original result appears. Reset driven low at cycle 20 of a div → Hi = Lo = 0, no `done`. A fresh mult of 3 × 5 afterwards yields Lo = 15, Hi = 0.
